// File: rtl/cc_geom_pkg.sv
// Shared types for the coordinate-geometry engine: job modes, FSM states, point record.
package cc_geom_pkg;

  localparam int unsigned PW = 16;  // widest supported coordinate; points stored sign-extended

  typedef enum logic [1:0] {M_RASTER, M_CIRCLE, M_AREA, M_BBOX} mode_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_EMIT} state_e;

  typedef struct packed {
    logic signed [PW-1:0] x;
    logic signed [PW-1:0] y;
  } point_t;

  function automatic int unsigned aw_of(input int unsigned cw);
    return 2 * cw + 4;
  endfunction

endpackage

// File: rtl/cc_floor_div.sv
// Combinational signed divide rounding toward -inf; a zero divisor yields zero.
module cc_floor_div #(
  parameter int W = 20
) (
  input  logic signed [W-1:0] num,
  input  logic signed [W-1:0] den,
  output logic signed [W-1:0] quo
);

  logic signed [W-1:0] q;
  logic signed [W-1:0] r;

  always_comb begin
    q = '0;
    r = '0;
    if (den != '0) begin
      q = num / den;
      r = num % den;
    end
    quo = q;
    if (r != '0 && (r[W-1] != den[W-1])) quo = q - W'(1);
  end

endmodule

// File: rtl/cc_geom_engine.sv
// Four-point geometry engine: trapezoid raster, line/circle test, quad area, bounding box.
module cc_geom_engine #(
  parameter int CW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic signed [CW-1:0] xi,
  input  logic signed [CW-1:0] yi,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [CW-1:0] xo,
  output logic signed [CW-1:0] yo,
  output logic                 out_last
);
  import cc_geom_pkg::*;

  localparam int AW = aw_of(CW);
  localparam logic signed [AW-1:0] ZERO = '0;

  state_e state, state_n;
  mode_e  mode_r;
  logic [1:0] cnt;
  point_t pt [4];
  logic beat, take;

  logic signed [AW-1:0] ax [4], ay [4];
  logic signed [AW-1:0] cross_v, r2, l2, shoe, area, minx, miny, maxx, maxy;
  logic signed [2*AW-1:0] lhs, rhs;
  logic signed [AW-1:0] cx, cxr, d, d1, h, num_l, num_r, q_l, q_r, xl_n, xr_n;
  logic signed [AW-1:0] n_cx, n_cxr, n_d;
  logic signed [CW-1:0] n_xo, n_yo;
  logic n_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = (state == S_IDLE) || (state == S_LOAD);
    beat     = in_valid && in_ready;
    take     = out_valid && out_ready;
    unique case (state)
      S_IDLE: if (beat) state_n = S_LOAD;
      S_LOAD: if (beat && cnt == 2'd3) state_n = S_CALC;
      S_CALC: state_n = S_EMIT;
      S_EMIT: if (take && out_last) state_n = S_IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      ax[2'(i)] = AW'(signed'(pt[2'(i)].x));
      ay[2'(i)] = AW'(signed'(pt[2'(i)].y));
    end
    cross_v = (ax[1] - ax[0]) * (ay[2] - ay[0]) - (ay[1] - ay[0]) * (ax[2] - ax[0]);
    r2   = (ax[3] - ax[2]) * (ax[3] - ax[2]) + (ay[3] - ay[2]) * (ay[3] - ay[2]);
    l2   = (ax[1] - ax[0]) * (ax[1] - ax[0]) + (ay[1] - ay[0]) * (ay[1] - ay[0]);
    lhs  = (2*AW)'(cross_v) * (2*AW)'(cross_v);
    rhs  = (2*AW)'(r2) * (2*AW)'(l2);
    shoe = ax[0] * ay[1] - ax[1] * ay[0] + ax[1] * ay[2] - ax[2] * ay[1]
         + ax[2] * ay[3] - ax[3] * ay[2] + ax[3] * ay[0] - ax[0] * ay[3];
    area = ((shoe < ZERO) ? -shoe : shoe) >>> 1;
    minx = ax[0]; maxx = ax[0]; miny = ay[0]; maxy = ay[0];
    for (int unsigned i = 1; i < 4; i++) begin
      if (ax[2'(i)] < minx) minx = ax[2'(i)];
      if (ax[2'(i)] > maxx) maxx = ax[2'(i)];
      if (ay[2'(i)] < miny) miny = ay[2'(i)];
      if (ay[2'(i)] > maxy) maxy = ay[2'(i)];
    end
    // next-row edges come straight from the divider so 1-point rows still stream every cycle
    h     = ay[2] - ay[0];
    d1    = d + AW'(1);
    num_l = d1 * (ax[2] - ax[0]);
    num_r = d1 * (ax[3] - ax[1]);
    xl_n  = ax[0] + q_l;
    xr_n  = ax[1] + q_r;
  end

  cc_floor_div #(.W(AW)) u_div_l (.num(num_l), .den(h), .quo(q_l));
  cc_floor_div #(.W(AW)) u_div_r (.num(num_r), .den(h), .quo(q_r));

  always_comb begin
    n_xo = xo; n_yo = yo; n_last = out_last;
    n_cx = cx; n_cxr = cxr; n_d = d;
    if (state == S_CALC) begin
      unique case (mode_r)
        M_RASTER: begin
          n_cx = ax[0]; n_cxr = ax[1]; n_d = ZERO;
          n_xo = CW'(ax[0]); n_yo = CW'(ay[0]);
          n_last = (ax[0] >= ax[1]) && (h <= ZERO);
        end
        M_CIRCLE: begin
          n_xo = '0;
          n_yo = (lhs > rhs) ? CW'(0) : ((lhs < rhs) ? CW'(1) : CW'(2));
          n_last = 1'b1;
        end
        M_AREA: begin
          n_xo = area[2*CW-1:CW]; n_yo = area[CW-1:0]; n_last = 1'b1;
        end
        M_BBOX: begin
          n_xo = CW'(minx); n_yo = CW'(miny); n_last = 1'b0;
        end
      endcase
    end else if (mode_r == M_RASTER) begin
      if (cx >= cxr) begin
        n_d = d1; n_cx = xl_n; n_cxr = xr_n;
      end else begin
        n_cx = cx + AW'(1);
      end
      n_xo   = CW'(n_cx);
      n_yo   = CW'(ay[0] + n_d);
      n_last = (n_cx >= n_cxr) && (n_d >= h);
    end else begin
      n_xo = CW'(maxx); n_yo = CW'(maxy); n_last = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0; mode_r <= M_RASTER; pt <= '{default: '0};
      out_valid <= 1'b0; xo <= '0; yo <= '0; out_last <= 1'b0;
      cx <= '0; cxr <= '0; d <= '0;
    end else begin
      if (beat) begin
        pt[cnt] <= '{x: PW'(xi), y: PW'(yi)};
        cnt     <= cnt + 2'd1;
        if (state == S_IDLE) mode_r <= mode_e'(mode);
      end
      if (state == S_CALC || (state == S_EMIT && take && !out_last)) begin
        out_valid <= 1'b1;
        xo <= n_xo; yo <= n_yo; out_last <= n_last;
        cx <= n_cx; cxr <= n_cxr; d <= n_d;
      end else if (state == S_EMIT && take) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
